// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory arbiter and its lane formatter.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/dm_lane.sv
// Combinational byte-lane formatter: store side gives be/din/err, load side gives
// the aligned and extended read result.
module dm_lane
    import dm_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_i,
    input  logic        sext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_dout_i,
    output logic [3:0]  be_o,
    output logic [31:0] din_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);

    logic [15:0] halfVal;
    logic [7:0]  byteVal;

    always_comb begin
        halfVal = addr_i[1] ? mem_dout_i[31:16] : mem_dout_i[15:0];
        case (addr_i)
            2'd0:    byteVal = mem_dout_i[7:0];
            2'd1:    byteVal = mem_dout_i[15:8];
            2'd2:    byteVal = mem_dout_i[23:16];
            default: byteVal = mem_dout_i[31:24];
        endcase
    end

    // Replicated store data lets the memory pick its lane from din[15:0]/din[7:0].
    always_comb begin
        err_o   = 1'b0;
        be_o    = 4'b0000;
        din_o   = wdata_i;
        rdata_o = 32'h0;
        case (size_i)
            SZ_WORD: begin
                err_o   = (addr_i != 2'b00);
                be_o    = 4'b1111;
                rdata_o = mem_dout_i;
            end
            SZ_HALF: begin
                err_o   = addr_i[0];
                be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                din_o   = {2{wdata_i[15:0]}};
                rdata_o = {{16{sext_i & halfVal[15]}}, halfVal};
            end
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_i;
                din_o   = {4{wdata_i[7:0]}};
                rdata_o = {{24{sext_i & byteVal[7]}}, byteVal};
            end
            default: begin
                err_o = 1'b1;
            end
        endcase
        if (err_o) begin
            be_o    = 4'b0000;
            rdata_o = 32'h0;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the data memory: grant, one-cycle memory access, then a
// one-cycle done/err/rdata response on the granted port.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic [1:0]        p0_size,
    input  logic [1:0]        p1_size,
    input  logic              p0_sext,
    input  logic              p1_sext,
    input  logic [31:0]       p0_addr,
    input  logic [31:0]       p1_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [31:0]       p1_wdata,
    output logic              p0_done,
    output logic              p1_done,
    output logic              p0_err,
    output logic              p1_err,
    output logic [31:0]       p0_rdata,
    output logic [31:0]       p1_rdata,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_dout
);

    state_e            state_q;
    logic              lastGrant_q;
    logic              port_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic [1:0]        addr_q;
    logic              p0_done_q, p1_done_q;
    logic              p0_err_q, p1_err_q;
    logic [31:0]       p0_rdata_q, p1_rdata_q;
    logic [ADDR_W-3:0] mem_addr_q;
    logic [31:0]       mem_din_q;
    logic              mem_we_q;
    logic [3:0]        mem_be_q;

    logic              anyReq;
    logic              winPort_d;
    logic              winWe, winSext;
    logic [1:0]        winSize;
    logic [31:0]       winAddr, winWdata;
    logic [1:0]        laneSize, laneAddr;
    logic [3:0]        laneBe;
    logic [31:0]       laneDin, laneRdata, respRdata_d;
    logic              laneErr;
    logic              unusedHighAddr;

    assign unusedHighAddr = ^{p0_addr[31:ADDR_W], p1_addr[31:ADDR_W]};

    // On a tie the round-robin pointer favours the port that did not win last.
    always_comb begin
        anyReq = p0_req | p1_req;
        if (p0_req && p1_req) begin
            winPort_d = FIXED_PRIO ? 1'b0 : ~lastGrant_q;
        end else begin
            winPort_d = ~p0_req;
        end
        winWe    = winPort_d ? p1_we    : p0_we;
        winSize  = winPort_d ? p1_size  : p0_size;
        winSext  = winPort_d ? p1_sext  : p0_sext;
        winAddr  = winPort_d ? p1_addr  : p0_addr;
        winWdata = winPort_d ? p1_wdata : p0_wdata;
        laneSize = (state_q == ST_IDLE) ? winSize       : size_q;
        laneAddr = (state_q == ST_IDLE) ? winAddr[1:0]  : addr_q;
        respRdata_d = we_q ? 32'h0 : laneRdata;
    end

    dm_lane u_lane (
        .size_i     (laneSize),
        .addr_i     (laneAddr),
        .sext_i     (sext_q),
        .wdata_i    (winWdata),
        .mem_dout_i (mem_dout),
        .be_o       (laneBe),
        .din_o      (laneDin),
        .err_o      (laneErr),
        .rdata_o    (laneRdata)
    );

    // Memory controls are registered at grant so they are valid for the whole ACCESS cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lastGrant_q <= 1'b1;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            sext_q      <= 1'b0;
            addr_q      <= 2'b00;
            p0_done_q   <= 1'b0;
            p1_done_q   <= 1'b0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
            p0_rdata_q  <= 32'h0;
            p1_rdata_q  <= 32'h0;
            mem_addr_q  <= '0;
            mem_din_q   <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
        end else begin
            p0_done_q <= 1'b0;
            p1_done_q <= 1'b0;
            p0_err_q  <= 1'b0;
            p1_err_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= 4'b0000;
            case (state_q)
                ST_IDLE: begin
                    if (anyReq) begin
                        port_q      <= winPort_d;
                        lastGrant_q <= winPort_d;
                        we_q        <= winWe;
                        size_q      <= winSize;
                        sext_q      <= winSext;
                        addr_q      <= winAddr[1:0];
                        mem_addr_q  <= winAddr[ADDR_W-1:2];
                        mem_din_q   <= laneDin;
                        if (winWe && !laneErr) begin
                            mem_we_q <= 1'b1;
                            mem_be_q <= laneBe;
                        end
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (port_q) begin
                        p1_done_q  <= 1'b1;
                        p1_err_q   <= laneErr;
                        p1_rdata_q <= respRdata_d;
                    end else begin
                        p0_done_q  <= 1'b1;
                        p0_err_q   <= laneErr;
                        p0_rdata_q <= respRdata_d;
                    end
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign p0_done  = p0_done_q;
    assign p1_done  = p1_done_q;
    assign p0_err   = p0_err_q;
    assign p1_err   = p1_err_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_we   = mem_we_q;
    assign mem_be   = mem_be_q;

endmodule
